// File: rtl/seven_seg_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// clock_display_pkg : constants, digit index type and BCD->7-seg encoder
// shared by the clock core and the display driver.   Rev 1.0
// ============================================================================
package clock_display_pkg;

    localparam int         NUM_DIGITS = 6;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    typedef logic [2:0] digit_idx_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}; non-BCD values blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] i_bcd);
        logic [6:0] w_seg;
        case (i_bcd)
            4'd0:    w_seg = 7'b1000000;
            4'd1:    w_seg = 7'b1111001;
            4'd2:    w_seg = 7'b0100100;
            4'd3:    w_seg = 7'b0110000;
            4'd4:    w_seg = 7'b0011001;
            4'd5:    w_seg = 7'b0010010;
            4'd6:    w_seg = 7'b0000010;
            4'd7:    w_seg = 7'b1111000;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0010000;
            default: w_seg = SEG_BLANK;
        endcase
        return w_seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// seven_seg_scan_driver_if : digit codes and controls in, scanned display out.
// Rev 1.0
// ============================================================================
interface seven_seg_scan_driver_if;
    logic [6:0] hex2;
    logic [6:0] hex3;
    logic [6:0] hex4;
    logic [6:0] hex5;
    logic [6:0] hex6;
    logic [6:0] hex7;
    logic       enable;
    logic [3:0] brightness;
    logic [5:0] blink_mask;
    logic [6:0] seg;
    logic [5:0] an;
    logic       frame_start;

    modport master (
        output hex2, hex3, hex4, hex5, hex6, hex7, enable, brightness, blink_mask,
        input  seg, an, frame_start
    );

    modport slave (
        input  hex2, hex3, hex4, hex5, hex6, hex7, enable, brightness, blink_mask,
        output seg, an, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scan_driver_pulse_divider.sv
`default_nettype none
// ============================================================================
// pulse_divider : free-running 0..DIV-1 counter, o_tick high on the last count.
// Rev 1.0
// ============================================================================
module pulse_divider #(
    parameter int DIV = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    output logic      o_tick
);
    localparam int             c_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_W-1:0] c_LAST = c_W'(DIV - 1);

    logic [c_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_LAST);
endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// seven_seg_scan_driver : frame-coherent 6-digit multiplexed display driver
// with anti-ghost blanking, 16-level PWM and per-digit blink.   Rev 1.0
// ============================================================================
module seven_seg_scan_driver
    import clock_display_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 64,
    parameter int BLINK_HZ     = 2
) (
    input  wire logic               clk,
    input  wire logic               reset,
    seven_seg_scan_driver_if.slave  bus
);
    localparam int SLOT_DIV  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    // At least 4 bits so the PWM compare on slot_cnt[3:0] is always legal.
    localparam int c_SW = ($clog2(SLOT_DIV) > 4) ? $clog2(SLOT_DIV) : 4;

    localparam logic [c_SW-1:0] c_SLOT_LAST  = c_SW'(SLOT_DIV - 1);
    localparam logic [c_SW-1:0] c_BLANK      = c_SW'(BLANK_CYCLES);
    localparam digit_idx_t      c_LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

    generate
        if (SLOT_DIV <= BLANK_CYCLES + 1) begin : g_bad_slot_div
            $error("seven_seg_scan_driver: SLOT_DIV must exceed BLANK_CYCLES+1");
        end
    endgenerate

    logic [c_SW-1:0] r_slot_cnt;
    digit_idx_t      r_digit_idx;
    logic [6:0]      r_snap [NUM_DIGITS];
    logic            r_blink_phase;
    logic [6:0]      r_seg;
    logic [5:0]      r_an;
    logic            r_frame_start;

    logic [6:0]      w_hex [NUM_DIGITS];
    logic            w_slot_end;
    logic            w_blink_tick;
    logic            w_lit;

    assign w_hex[0] = bus.hex2;
    assign w_hex[1] = bus.hex3;
    assign w_hex[2] = bus.hex4;
    assign w_hex[3] = bus.hex5;
    assign w_hex[4] = bus.hex6;
    assign w_hex[5] = bus.hex7;

    pulse_divider #(
        .DIV (BLINK_DIV)
    ) u_blink_div (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_blink_tick)
    );

    assign w_slot_end = (r_slot_cnt == c_SLOT_LAST);

    assign w_lit = bus.enable
                && (r_slot_cnt >= c_BLANK)
                && (r_slot_cnt[3:0] <= bus.brightness)
                && !(bus.blink_mask[r_digit_idx] && r_blink_phase);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_cnt    <= '0;
            r_digit_idx   <= '0;
            r_blink_phase <= 1'b0;
            r_frame_start <= 1'b0;
            r_seg         <= SEG_BLANK;
            r_an          <= '1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_snap[i] <= SEG_BLANK;
            end
        end else begin
            // Pulse lines up with the cycle the scan state sits at digit 0, slot 0.
            r_frame_start <= w_slot_end && (r_digit_idx == c_LAST_DIGIT);

            if (w_slot_end) begin
                r_slot_cnt <= '0;
                if (r_digit_idx == c_LAST_DIGIT) begin
                    r_digit_idx <= '0;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        r_snap[i] <= w_hex[i];
                    end
                end else begin
                    r_digit_idx <= r_digit_idx + 1'b1;
                end
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end

            if (w_blink_tick) begin
                r_blink_phase <= ~r_blink_phase;
            end

            if (w_lit) begin
                r_seg <= r_snap[r_digit_idx];
                r_an  <= ~(6'b1 << r_digit_idx);
            end else begin
                r_seg <= SEG_BLANK;
                r_an  <= '1;
            end
        end
    end

    assign bus.seg         = r_seg;
    assign bus.an          = r_an;
    assign bus.frame_start = r_frame_start;
endmodule
`default_nettype wire
